// File: rtl/rs_latch_controller_pkg.sv
// Shared types and constants for the R-S latch bank controller.
// Imported by the arbiter and the controller top.
package rs_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;
  typedef enum logic {OP_SET, OP_CLR} op_t;

  localparam int ERR_CNT_W = 8;
  localparam int CNT_W     = 16;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/rs_rr_arbiter.sv
// Two-requester round-robin arbiter (set vs clear).
// The priority pointer flips after every grant.
module rs_rr_arbiter
  import rs_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       set_req,
  input  logic       clr_req,
  output logic [1:0] grant,
  output logic       grant_op
);

  op_t prio;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (set_req && (!clr_req || prio == OP_SET)) begin
        grant = 2'b01;
      end else if (clr_req) begin
        grant = 2'b10;
      end
    end
  end

  // OP_CLR is encoded as 1, so the clear grant bit doubles as the op.
  assign grant_op = grant[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio <= OP_SET;
    end else if (grant != 2'b00) begin
      prio <= (prio == OP_SET) ? OP_CLR : OP_SET;
    end
  end

endmodule

// File: rtl/rs_latch_controller.sv
// Sequences timed S/R pulses into a bank of external R-S latches and
// verifies each latch's Q afterwards; never drives S and R together.
module rs_latch_controller
  import rs_ctrl_pkg::*;
#(
  parameter int N_LATCH       = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int IDX_W         = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 set_valid,
  input  logic [IDX_W-1:0]     set_idx,
  output logic                 set_ready,
  input  logic                 clr_valid,
  input  logic [IDX_W-1:0]     clr_idx,
  output logic                 clr_ready,
  output logic [N_LATCH-1:0]   latch_s,
  output logic [N_LATCH-1:0]   latch_r,
  input  logic [N_LATCH-1:0]   latch_q,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t             state, state_next;
  op_t                op_q, op_next, gop;
  logic [IDX_W-1:0]   idx_q, idx_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               force_q, force_next;
  logic               done_next, err_next;
  logic [N_LATCH-1:0] s_next, r_next;
  logic [1:0]         grant;
  logic               grant_op;

  function automatic logic in_range(input logic [IDX_W-1:0] i);
    return 32'(i) < N_LATCH;
  endfunction

  function automatic logic q_at(input logic [N_LATCH-1:0] q, input logic [IDX_W-1:0] i);
    return in_range(i) ? q[i] : 1'b0;
  endfunction

  rs_rr_arbiter u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (state == IDLE),
    .set_req  (set_valid),
    .clr_req  (clr_valid),
    .grant    (grant),
    .grant_op (grant_op)
  );

  assign gop       = op_t'(grant_op);
  assign set_ready = grant[0];
  assign clr_ready = grant[1];
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    op_next    = op_q;
    idx_next   = idx_q;
    cnt_next   = cnt;
    force_next = force_q;
    done_next  = 1'b0;
    err_next   = 1'b0;
    s_next     = '0;
    r_next     = '0;

    unique case (state)
      IDLE: begin
        if (grant != 2'b00) begin
          op_next    = gop;
          idx_next   = (gop == OP_SET) ? set_idx : clr_idx;
          force_next = !in_range(idx_next);
          // Out-of-range and already-correct latches go straight to CHECK.
          if (force_next || (q_at(latch_q, idx_next) == (gop == OP_SET))) begin
            state_next = CHECK;
          end else begin
            state_next = PULSE;
            cnt_next   = PULSE_LOAD;
          end
        end
      end
      PULSE: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else if (SETTLE_CYCLES == 0) begin
          state_next = CHECK;
        end else begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        state_next = IDLE;
        if (force_q || (q_at(latch_q, idx_q) != (op_q == OP_SET))) begin
          err_next = 1'b1;
        end else begin
          done_next = 1'b1;
        end
      end
    endcase

    // Pulse lines are registered, so they follow the state being entered.
    if (state_next == PULSE) begin
      if (op_next == OP_SET) begin
        s_next = N_LATCH'(1) << idx_next;
      end else begin
        r_next = N_LATCH'(1) << idx_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_q    <= OP_SET;
      idx_q   <= '0;
      cnt     <= '0;
      force_q <= 1'b0;
      latch_s <= '0;
      latch_r <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_next;
      op_q    <= op_next;
      idx_q   <= idx_next;
      cnt     <= cnt_next;
      force_q <= force_next;
      latch_s <= s_next;
      latch_r <= r_next;
      done    <= done_next;
      err     <= err_next;
      if (err_next) begin
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_rs_latch_controller.sv
// Self-checking bench for rs_latch_controller: a transaction-level model
// predicts grants, pulse shapes, latency and err_cnt for random requests.
module tb_rs_latch_controller;

  localparam int N = 4;
  localparam int P = 2;
  localparam int S = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       set_valid, clr_valid, set_ready, clr_ready;
  logic [1:0] set_idx, clr_idx;
  logic [3:0] latch_s, latch_r, latch_q;
  logic       busy, done, err;
  logic [7:0] err_cnt;

  logic       s2_valid, s2_ready, c2_ready, b2, d2, e2;
  logic [1:0] s2_idx;
  logic [2:0] s2_s, s2_r;
  logic [2:0] q2 = 3'b000;
  logic [7:0] ec2;

  rs_latch_controller #(.N_LATCH(N), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset_n(reset_n),
    .set_valid(set_valid), .set_idx(set_idx), .set_ready(set_ready),
    .clr_valid(clr_valid), .clr_idx(clr_idx), .clr_ready(clr_ready),
    .latch_s(latch_s), .latch_r(latch_r), .latch_q(latch_q),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  rs_latch_controller #(.N_LATCH(3), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .set_valid(s2_valid), .set_idx(s2_idx), .set_ready(s2_ready),
    .clr_valid(1'b0), .clr_idx(2'b00), .clr_ready(c2_ready),
    .latch_s(s2_s), .latch_r(s2_r), .latch_q(q2),
    .busy(b2), .done(d2), .err(e2), .err_cnt(ec2)
  );

  // Behavioural latch bank; "stuck" freezes Q, q_load forces a value.
  logic       stuck = 1'b0, q_load = 1'b0;
  logic [3:0] q_load_val = 4'b0, q_env = 4'b0;
  always @(posedge clk) begin
    if (q_load) q_env <= q_load_val;
    else if (!stuck) q_env <= (q_env | latch_s) & ~latch_r;
  end
  assign latch_q = q_env;

  int   vectors = 0, miscompares = 0;
  bit   ptr;
  logic [3:0] q_ref;
  int   exp_ec;
  bit   set_pend, clr_pend;
  int   set_i, clr_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_q(input logic [3:0] v);
    set_valid = 1'b0;
    clr_valid = 1'b0;
    q_load = 1'b1;
    q_load_val = v;
    @(negedge clk);
    q_load = 1'b0;
    q_ref = v;
    #1;
  endtask

  // One grant and its full transaction, predicted from the rules alone.
  task automatic run_txn();
    bit g_set, expv, pulse, good;
    int idx, lat;
    logic [3:0] onehot, exp_s, exp_r;
    set_valid = set_pend; set_idx = 2'(set_i);
    clr_valid = clr_pend; clr_idx = 2'(clr_i);
    #1;
    if (!set_pend && !clr_pend) return;
    g_set = set_pend && (!clr_pend || ptr == 1'b0);
    check("set_ready", set_ready, g_set);
    check("clr_ready", clr_ready, !g_set);
    ptr = !ptr;
    idx = g_set ? set_i : clr_i;
    expv = g_set;
    pulse = 1'b0; lat = 2; good = 1'b1;
    if (q_ref[idx] != expv) begin
      pulse = 1'b1;
      lat = P + S + 2;
      good = !stuck;
      if (!stuck) q_ref[idx] = expv;
    end
    if (g_set) set_pend = 1'b0; else clr_pend = 1'b0;
    onehot = 4'b0001 << idx;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      set_valid = (k < lat) ? set_pend : 1'b0;
      clr_valid = (k < lat) ? clr_pend : 1'b0;
      #1;
      exp_s = (pulse && g_set && k <= P) ? onehot : 4'b0;
      exp_r = (pulse && !g_set && k <= P) ? onehot : 4'b0;
      check("latch_s", latch_s, exp_s);
      check("latch_r", latch_r, exp_r);
      check("busy", busy, k < lat);
      check("done", done, (k == lat) && good);
      check("err", err, (k == lat) && !good);
      if (k < lat) check("ready_busy", {set_ready, clr_ready}, 2'b00);
    end
    if (!good && exp_ec < 255) exp_ec++;
    check("err_cnt", err_cnt, exp_ec);
    check("q_bank", q_env, q_ref);
  endtask

  initial begin
    reset_n = 1'b0;
    set_valid = 1'b0; clr_valid = 1'b0; set_idx = 2'd0; clr_idx = 2'd0;
    s2_valid = 1'b0; s2_idx = 2'd0;
    set_pend = 1'b0; clr_pend = 1'b0; set_i = 0; clr_i = 0;
    q_load = 1'b1; q_load_val = 4'b0;
    repeat (3) @(negedge clk);
    q_load = 1'b0;
    #1;
    check("rst_latch_s", latch_s, 4'b0);
    check("rst_latch_r", latch_r, 4'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    reset_n = 1'b1;
    ptr = 1'b0; q_ref = 4'b0; exp_ec = 0;

    // Both requesters valid right after reset, then keep both saturated.
    set_pend = 1'b1; set_i = 1; clr_pend = 1'b1; clr_i = 3;
    run_txn();
    for (int t = 0; t < 5; t++) begin
      if (!set_pend) begin set_pend = 1'b1; set_i = $urandom_range(0, 3); end
      if (!clr_pend) begin clr_pend = 1'b1; clr_i = $urandom_range(0, 3); end
      run_txn();
    end
    set_pend = 1'b0; clr_pend = 1'b0;

    // Single set on an all-zero bank.
    load_q(4'b0000);
    set_pend = 1'b1; set_i = 2;
    run_txn();

    // Redundant clear: no R pulse, short latency.
    load_q(4'b0000);
    clr_pend = 1'b1; clr_i = 0;
    run_txn();

    // Stuck latch: every set fails, err_cnt saturates.
    stuck = 1'b1;
    load_q(4'b0000);
    for (int t = 0; t < 261; t++) begin
      set_pend = 1'b1; set_i = 1;
      run_txn();
    end
    check("err_cnt_sat", err_cnt, 8'd255);
    stuck = 1'b0;

    // Reset during the second pulse cycle.
    load_q(4'b0000);
    set_valid = 1'b1; set_idx = 2'd3;
    #1;
    check("mid_ready", set_ready, 1'b1);
    @(negedge clk);
    set_valid = 1'b0;
    #1;
    check("mid_pulse1", latch_s, 4'b1000);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_pulse2", latch_s, 4'b1000);
    @(negedge clk);
    #1;
    check("mid_rst_s", latch_s, 4'b0);
    check("mid_rst_r", latch_r, 4'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_err_cnt", err_cnt, 8'd0);
    reset_n = 1'b1;
    ptr = 1'b0; exp_ec = 0; q_ref = 4'b1000;
    check("mid_q_env", q_env, q_ref);
    set_pend = 1'b1; set_i = 0; clr_pend = 1'b1; clr_i = 3;
    run_txn();
    run_txn();

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      if (!set_pend && $urandom_range(0, 2) != 0) begin
        set_pend = 1'b1; set_i = $urandom_range(0, 3);
      end
      if (!clr_pend && $urandom_range(0, 2) != 0) begin
        clr_pend = 1'b1; clr_i = $urandom_range(0, 3);
      end
      if (!set_pend && !clr_pend) begin
        set_pend = 1'b1; set_i = $urandom_range(0, 3);
      end
      run_txn();
    end
    set_pend = 1'b0; clr_pend = 1'b0;
    set_valid = 1'b0; clr_valid = 1'b0;

    // Out-of-range index on a 3-latch bank.
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      s2_valid = 1'b1; s2_idx = 2'd3;
      #1;
      check("oor_ready", s2_ready, 1'b1);
      @(negedge clk);
      s2_valid = 1'b0;
      #1;
      check("oor_s1", s2_s, 3'b0);
      check("oor_r1", s2_r, 3'b0);
      check("oor_busy", b2, 1'b1);
      check("oor_err1", e2, 1'b0);
      @(negedge clk);
      #1;
      check("oor_s2", s2_s, 3'b0);
      check("oor_err2", e2, 1'b1);
      check("oor_done", d2, 1'b0);
      check("oor_err_cnt", ec2, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
